// File: rtl/branch_seq_if.sv
// branch_seq_if -- decode-to-sequencer control-transfer handshake.
//
// Signals:
//   br_valid   decode presents a control-transfer instruction
//   br_ready   sequencer accepts the instruction this cycle
//   br_kind    00 cond branch, 01 JAL, 10 JALR, 11 reserved
//   br_funct3  RV32I branch funct3 (compare code)
//   br_pc      address of the instruction
//   br_imm     sign-extended offset
//   br_rs1/2   register operands
//
// Modports: master = decode side, slave = sequencer side.
interface branch_seq_if;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_kind;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;
    logic [31:0] br_rs2;

    modport master (
        output br_valid, br_kind, br_funct3, br_pc, br_imm, br_rs1, br_rs2,
        input  br_ready
    );

    modport slave (
        input  br_valid, br_kind, br_funct3, br_pc, br_imm, br_rs1, br_rs2,
        output br_ready
    );
endinterface

// File: rtl/branch_seq.sv
// branch_seq -- fetch PC sequencer with branch/jump resolution.
//
// Advances the fetch PC sequentially, accepts control-transfer instructions
// from decode, drives an external branch compare unit for conditional
// branches and redirects fetch on taken branches and jumps.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   br              decode handshake (branch_seq_if.slave)
//   stall           fetch backpressure; freezes sequential PC advance
//   comp_type       compare code to the compare unit (3'b010 = idle)
//   comp_reg1/2     compare operands to the compare unit
//   branch_taken    registered compare result, valid one cycle after operands
//   pc              current fetch address
//   fetch_en        fetch may issue at pc
//   redirect        one-cycle pulse, pc holds a non-sequential target
//   link            br_pc+4 of the last accepted instruction
//   link_valid      one-cycle pulse, link valid for write-back
//   misalign        one-cycle pulse, taken target not 4-byte aligned
module branch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    branch_seq_if.slave       br,
    input  logic              stall,
    output logic [2:0]        comp_type,
    output logic [31:0]       comp_reg1,
    output logic [31:0]       comp_reg2,
    input  logic              branch_taken,
    output logic [31:0]       pc,
    output logic              fetch_en,
    output logic              redirect,
    output logic [31:0]       link,
    output logic              link_valid,
    output logic              misalign
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMP     = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;

    // Code 010 makes the compare unit output 0; used whenever no branch is in flight.
    localparam logic [2:0] CMP_NONE  = 3'b010;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic        link_valid_q, link_valid_d;
    logic        misalign_q, misalign_d;
    logic [2:0]  comp_type_q, comp_type_d;
    logic [31:0] comp_reg1_q, comp_reg1_d;
    logic [31:0] comp_reg2_q, comp_reg2_d;
    logic [31:0] link_q, link_d;
    logic [31:0] tgt_q, tgt_d;

    logic        br_ready_s;
    logic        hs_s;
    logic [31:0] jump_tgt_s;
    logic        taken_s;

    // No accept while a branch is in flight or during the redirect cycle.
    assign br_ready_s = (state_q == S_IDLE) & ~redirect_q & ~stall;
    assign br.br_ready = br_ready_s;
    assign hs_s       = br.br_valid & br_ready_s;

    // JALR clears bit 0 of its target; JAL is plain pc-relative.
    assign jump_tgt_s = (br.br_kind == KIND_JALR)
                      ? ((br.br_rs1 + br.br_imm) & ~32'd1)
                      : (br.br_pc + br.br_imm);

    // Reserved compare codes always resolve as not taken.
    assign taken_s = branch_taken & (comp_type_q != 3'b010) & (comp_type_q != 3'b011);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a conditional branch leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s && (br.br_kind == KIND_BR)) begin
                    state_d = S_CMP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP:     state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next-state logic.
    always_comb begin
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        link_valid_d = 1'b0;
        misalign_d   = 1'b0;
        comp_type_d  = comp_type_q;
        comp_reg1_d  = comp_reg1_q;
        comp_reg2_d  = comp_reg2_q;
        link_d       = link_q;
        tgt_d        = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    link_d = br.br_pc + 32'd4;
                    case (br.br_kind)
                        KIND_BR: begin
                            // Latch everything now so later input changes cannot matter.
                            comp_type_d = br.br_funct3;
                            comp_reg1_d = br.br_rs1;
                            comp_reg2_d = br.br_rs2;
                            tgt_d       = br.br_pc + br.br_imm;
                        end
                        KIND_JAL, KIND_JALR: begin
                            if (jump_tgt_s[1:0] == 2'b00) begin
                                pc_d         = jump_tgt_s;
                                redirect_d   = 1'b1;
                                link_valid_d = 1'b1;
                            end else begin
                                misalign_d   = 1'b1;
                            end
                        end
                        default: begin
                            pc_d = pc_q;
                        end
                    endcase
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_CMP: begin
                pc_d = pc_q;
            end
            S_RESOLVE: begin
                comp_type_d = CMP_NONE;
                if (taken_s) begin
                    if (tgt_q[1:0] == 2'b00) begin
                        pc_d       = tgt_q;
                        redirect_d = 1'b1;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    // link_q still holds br_pc+4 of this branch.
                    pc_d = link_q;
                end
            end
            default: begin
                comp_type_d = CMP_NONE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            redirect_q   <= 1'b0;
            link_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            comp_type_q  <= CMP_NONE;
            comp_reg1_q  <= 32'd0;
            comp_reg2_q  <= 32'd0;
            link_q       <= 32'd0;
            tgt_q        <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            link_valid_q <= link_valid_d;
            misalign_q   <= misalign_d;
            comp_type_q  <= comp_type_d;
            comp_reg1_q  <= comp_reg1_d;
            comp_reg2_q  <= comp_reg2_d;
            link_q       <= link_d;
            tgt_q        <= tgt_d;
        end
    end

    assign pc         = pc_q;
    assign fetch_en   = (state_q == S_IDLE);
    assign redirect   = redirect_q;
    assign link       = link_q;
    assign link_valid = link_valid_q;
    assign misalign   = misalign_q;
    assign comp_type  = comp_type_q;
    assign comp_reg1  = comp_reg1_q;
    assign comp_reg2  = comp_reg2_q;

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  fetch backpressure; freezes sequential PC advance
- br_valid  in  1  decode presents control-transfer instruction
- br_ready  out  1  sequencer accepts instruction this cycle
- br_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved
- br_funct3  in  3  RV32I branch funct3
- br_pc  in  32  address of the instruction
- br_imm  in  32  sign-extended offset
- br_rs1, br_rs2  in  32  register operands
- comp_type  out  3  compare code to branch compare unit
- comp_reg1, comp_reg2  out  32  compare operands to branch compare unit
- branch_taken  in  1  compare result, registered, valid 1 cycle after operands driven
- pc  out  32  current fetch address
- fetch_en  out  1  fetch may issue at pc
- redirect  out  1  one-cycle pulse: pc is a non-sequential target; flush younger instructions
- link  out  32  br_pc+4 for rd write-back
- link_valid  out  1  one-cycle pulse, link valid
- misalign  out  1  one-cycle pulse, taken target not 4-byte aligned

Function
REQ-004 SHALL implement FSM states IDLE, CMP, RESOLVE, all registered.
REQ-005 br_ready SHALL equal (state==IDLE) & !redirect & !stall; handshake = br_valid & br_ready.
REQ-006 In IDLE without handshake, pc SHALL advance by 4 (mod 2^32) per cycle when !stall, hold when stall.
REQ-007 fetch_en SHALL be high only in IDLE; pc SHALL hold in CMP and RESOLVE regardless of stall.
REQ-008 Handshake, br_kind=00: comp_type<=br_funct3, comp_reg1<=br_rs1, comp_reg2<=br_rs2, pc held, IDLE->CMP.
REQ-009 CMP SHALL last exactly 1 cycle, hold comp_* stable, then ->RESOLVE.
REQ-010 In RESOLVE, branch_taken SHALL be sampled; taken and target[1:0]==0: pc<=br_pc+br_imm, redirect high next cycle; not taken: pc<=br_pc+4, no redirect; state ->IDLE.
REQ-011 Branch accept-to-redirect latency SHALL be 3 cycles (accept edge, CMP, RESOLVE; pulse in 3rd cycle after accept).
REQ-012 Handshake, br_kind=01 (JAL): pc<=br_pc+br_imm; redirect and link_valid high next cycle; state stays IDLE.
REQ-013 Handshake, br_kind=10 (JALR): target=(br_rs1+br_imm)&~1; otherwise as REQ-012.
REQ-014 link SHALL be br_pc+4, registered at accept, held until next accept.
REQ-015 Taken target with bit1 set: misalign SHALL pulse 1 cycle; redirect and link_valid low; pc unchanged; state ->IDLE.
REQ-016 Reserved br_funct3 010/011 SHALL be passed to the compare unit unchanged and resolve as not taken.
REQ-017 br_kind=11 SHALL be accepted and dropped: no pc change, no pulses.
REQ-018 Outside CMP/RESOLVE, comp_type SHALL be 3'b010 so that the compare unit outputs 0.
REQ-019 In the redirect cycle, pc=target and pc SHALL advance per REQ-006 at the end of that cycle; br_valid SHALL be ignored.
REQ-020 Operand fields SHALL be latched at accept; input changes after accept SHALL NOT affect resolution.

Reset
REQ-021 On rst: state=IDLE, pc=RESET_PC, comp_type=3'b010, comp_reg1/2=0, link=0, redirect/link_valid/misalign=0.
REQ-022 rst during CMP or RESOLVE SHALL abort: no redirect, no misalign pulse.
REQ-023 br_ready SHALL be 1 in the first cycle after rst deasserts if !stall.

Verification
REQ-024 Reset release, stall=0 -> pc 0x0, 0x4, 0x8 over consecutive cycles; redirect 0.
REQ-025 BEQ, br_pc=0x100, imm=0x20, rs1=rs2=5 -> comp_type=000 in CMP; redirect in 3rd cycle after accept with pc=0x120.
REQ-026 rs1=0xFFFFFFFF, rs2=1: BLT -> taken; BLTU -> pc=0x104, no redirect.
REQ-027 JAL br_pc=0x40, imm=-8 -> next cycle pc=0x38, redirect=1, link=0x44, link_valid=1; JALR rs1=0x203, imm=0 -> misalign=1, pc unchanged.
REQ-028 rst asserted in RESOLVE of taken BEQ -> no redirect, pc=RESET_PC, br_ready=1 after release.
REQ-029 br_valid held high through redirect cycle -> br_ready=0 that cycle; accept only on following cycle.
